// File: rtl/shift_right_seq_if.sv
// shift_right_seq_if: request/result bundle for the sequential right shifter (arith only with ARITH_SHIFT_EN)
interface shift_right_seq_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 3
);
    logic               start;
    logic [WIDTH-1:0]   x;
    logic [COUNT_W-1:0] amt;
`ifdef ARITH_SHIFT_EN
    logic               arith;
`endif
    logic [WIDTH-1:0]   f;
    logic               cout;
    logic               sticky;
    logic               busy;
    logic               done;

    modport master (
`ifdef ARITH_SHIFT_EN
        output arith,
`endif
        output start, x, amt,
        input  f, cout, sticky, busy, done
    );

    modport slave (
`ifdef ARITH_SHIFT_EN
        input  arith,
`endif
        input  start, x, amt,
        output f, cout, sticky, busy, done
    );
endinterface

// File: rtl/shift_right_seq.sv
// shift_right_seq: one-bit-per-clock right shifter with cout/sticky; ARITH_SHIFT_EN adds sign fill via arith
module shift_right_seq #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 3
) (
    input logic              clk,
    input logic              rst_n,
    shift_right_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    state_t             state_nx;
    logic [COUNT_W-1:0] cnt;
    logic               fill;
    logic               accept;

    assign accept   = (state == IDLE) && bus.start;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

`ifdef ARITH_SHIFT_EN
    logic arith_q;
    assign fill = arith_q & bus.f[WIDTH-1];
    // Fill mode is latched with the operand so later arith changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arith_q <= 1'b0;
        else if (accept) arith_q <= bus.arith;
    end
`else
    assign fill = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // Next state: zero amount skips straight to DONE; DONE always returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = (bus.amt != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt == COUNT_W'(1)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift one bit per SHIFT cycle, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.f      <= '0;
            bus.cout   <= 1'b0;
            bus.sticky <= 1'b0;
            cnt        <= '0;
        end else if (accept) begin
            bus.f      <= bus.x;
            bus.cout   <= 1'b0;
            bus.sticky <= 1'b0;
            cnt        <= bus.amt;
        end else if (state == SHIFT) begin
            bus.f      <= {fill, bus.f[WIDTH-1:1]};
            bus.cout   <= bus.f[0];
            bus.sticky <= bus.sticky | bus.cout;
            cnt        <= cnt - COUNT_W'(1);
        end
    end
endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Sequential right shifter for the shift datapath. It is the counterpart of the combinational one-bit left shifter. The block captures a WIDTH-bit operand and a shift amount, then shifts right one bit per clock. It reports the last bit shifted out (cout) and a sticky OR of all earlier shifted-out bits, and signals completion with a one-cycle done pulse. It is used wherever a multi-bit right shift is needed without a full barrel-shifter mux tree.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- COUNT_W, 3, width of shift-amount port; maximum shift = 2^COUNT_W − 1 (must be ≤ WIDTH)

- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- x  input  WIDTH  operand, captured when start accepted
- amt  input  COUNT_W  shift amount, captured when start accepted
- arith  input  1  arithmetic-shift select, captured on start (present only with ARITH_SHIFT_EN)
- f  output  WIDTH  result register
- cout  output  1  last bit shifted out
- sticky  output  1  OR of all shifted-out bits except the last
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle completion pulse

## Operation
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, f=0, cout=0, sticky=0, remaining-count=0, busy=0, done=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: f<=x, cnt<=amt, cout<=0, sticky<=0.
  - Next state is SHIFT if amt≠0, otherwise DONE.
  - Fill mode is latched at the same edge.
- SHIFT, each edge:
  - f<={fill, f[WIDTH-1:1]}; cout<=f[0]; sticky<=sticky|cout; cnt<=cnt−1.
  - When cnt==1 (last shift), next state is DONE.
- DONE: done=1 for exactly this cycle; next state is IDLE unconditionally.
- fill is 0, or f[WIDTH-1] when arithmetic mode is latched (see Configuration).
- start is ignored while busy=1, including during DONE. There is no queuing.
- f, cout and sticky hold their values after done until the next accepted start.
- x, amt and arith may change freely after the start edge.

## Timing
- A start accepted at edge E0 with amt=k (k>0) gives k SHIFT edges (E1..Ek).
  - done=1 in the cycle after Ek (between Ek and Ek+1).
  - busy=1 from E0 to Ek+1.
- amt=0: done=1 in the cycle after E0; f=x, cout=0, sticky=0.
- Back-to-back: the earliest next start is sampled at the edge that ends the DONE cycle plus one, i.e. the first IDLE cycle. Total throughput is k+2 cycles per operation.
- Outputs are registered, except busy and done, which decode the state register directly.
- rst_n low mid-operation forces all reset values immediately. There is no done pulse for the aborted operation.

## Configuration
- Macro: ARITH_SHIFT_EN.
- Defined:
  - The arith port exists and is captured on start.
  - arith=1 fills with the captured sign bit (f[WIDTH-1] each cycle, which stays constant).
  - arith=0 fills with 0.
- Undefined: no arith port; fill is always 0 (logical shift).

## Test plan
- x=0x01, amt=1 → f=0x00, cout=1, sticky=0, done 2 cycles after the start edge.
- x=0x60, amt=5 → f=0x03, cout=0, sticky=0, busy high for 6 cycles.
- x=0xB5, amt=3 → logical: f=0x16, cout=1, sticky=1. With ARITH_SHIFT_EN and arith=1: f=0xF6, cout=1, sticky=1.
- x=0x80, amt=0 → f=0x80, cout=0, sticky=0, done the cycle after start.
- x=0xFF, amt=7, start held high continuously → f=0x01, cout=1, sticky=1. The second operation starts only in the first IDLE cycle after done; pulses in SHIFT/DONE are ignored.
- x=0xF0, amt=6, rst_n pulsed low after 2 shifts → f=0, cout=0, sticky=0, busy=0, no done pulse. A subsequent start behaves normally.
